// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle control sequencer for the 4-bit-opcode core. Owns the program
// counter and the instruction register. Each instruction moves through
// FETCH -> DECODE -> (EXEC | MEM) -> (WB) -> FETCH. BEZ/BNZ are resolved in
// DECODE. The block also issues one-cycle enables to the ALU and register file.
// The opcode decoder elsewhere in the core reads ir[15:12]. This block only
// decides *when* its effects take place.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   imem_req     instruction fetch request (held until imem_ack)
//   imem_addr    fetch address, always equal to pc
//   imem_ack     fetch complete, imem_rdata valid this cycle
//   imem_rdata   instruction word
//   dmem_req     data memory request (held until dmem_ack)
//   dmem_we      1 = store, 0 = load; meaningful while dmem_req
//   dmem_ack     data access complete
//   zero         branch operand is zero; sampled in DECODE
//   pc           current program counter
//   ir           instruction register, ir[15:12] is the opcode
//   alu_en       one-cycle ALU result load strobe
//   rf_we        one-cycle register-file write strobe
//   retire       one-cycle pulse per completed instruction
//   illegal      one-cycle pulse for an unassigned opcode
//   halted       level, core stopped until reset
//   retired_cnt  wrapping count of retired instructions
//   state        FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    input  logic            zero,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     ir,
    output logic            alu_en,
    output logic            rf_we,
    output logic            retire,
    output logic            illegal,
    output logic            halted,
    output logic [15:0]     retired_cnt,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LW      = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BR      = 3'd4,
        CLS_HALT    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_t;

    // Maps a 4-bit opcode onto the class that drives the sequencing decision.
    function automatic op_class_t classify(input logic [3:0] op);
        op_class_t cls;
        case (op)
            4'h0:                               cls = CLS_NOP;
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: cls = CLS_ALU;
            4'h8:                               cls = CLS_LW;
            4'h9, 4'hA:                         cls = CLS_STORE;
            4'hC, 4'hD:                         cls = CLS_BR;
            4'hF:                               cls = CLS_HALT;
            default:                            cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    state_t          state_r;
    logic [PC_W-1:0] pc_r;
    logic [15:0]     ir_r;
    logic [15:0]     retired_cnt_r;

    op_class_t       op_class_s;
    logic            br_taken_s;
    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] br_off_s;
    logic [PC_W-1:0] pc_br_s;

    logic            imem_req_s;
    logic            dmem_req_s;
    logic            dmem_we_s;
    logic            alu_en_s;
    logic            rf_we_s;
    logic            retire_s;
    logic            illegal_s;

    // Instruction classification and next-PC candidates.
    always_comb begin
        op_class_s = classify(ir_r[15:12]);
        // BEZ (C) is taken on zero, BNZ (D) on non-zero.
        br_taken_s = ((ir_r[15:12] == 4'hC) && zero) ||
                     ((ir_r[15:12] == 4'hD) && !zero);
        pc_inc_s   = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        // Sign-extend the 8-bit offset, then truncate so the sum wraps mod 2^PC_W.
        br_off_s   = PC_W'({{24{ir_r[7]}}, ir_r[7:0]});
        pc_br_s    = pc_inc_s + br_off_s;
    end

    // Requests and strobes, decoded from the current state and IR.
    always_comb begin
        imem_req_s = 1'b0;
        dmem_req_s = 1'b0;
        dmem_we_s  = 1'b0;
        alu_en_s   = 1'b0;
        rf_we_s    = 1'b0;
        retire_s   = 1'b0;
        illegal_s  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                imem_req_s = 1'b1;
            end
            ST_DECODE: begin
                // Everything that finishes in DECODE retires here.
                if ((op_class_s == CLS_NOP) || (op_class_s == CLS_ILLEGAL) ||
                    (op_class_s == CLS_BR)  || (op_class_s == CLS_HALT)) begin
                    retire_s = 1'b1;
                end else begin
                    retire_s = 1'b0;
                end
                if (op_class_s == CLS_ILLEGAL) begin
                    illegal_s = 1'b1;
                end else begin
                    illegal_s = 1'b0;
                end
            end
            ST_EXEC: begin
                alu_en_s = 1'b1;
            end
            ST_MEM: begin
                dmem_req_s = 1'b1;
                if (op_class_s == CLS_STORE) begin
                    dmem_we_s = 1'b1;
                    // A store has no WB, so it completes on the ack cycle.
                    retire_s  = dmem_ack;
                end else begin
                    dmem_we_s = 1'b0;
                    retire_s  = 1'b0;
                end
            end
            ST_WB: begin
                rf_we_s  = 1'b1;
                retire_s = 1'b1;
            end
            ST_HALT: begin
                imem_req_s = 1'b0;
            end
            default: begin
                imem_req_s = 1'b0;
            end
        endcase
    end

    // Sequencer state, PC, IR and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_PC;
            ir_r          <= 16'h0000;
            retired_cnt_r <= 16'h0000;
        end else begin
            if (retire_s) begin
                retired_cnt_r <= retired_cnt_r + 16'd1;
            end else begin
                retired_cnt_r <= retired_cnt_r;
            end

            case (state_r)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_r    <= imem_rdata;
                        state_r <= ST_DECODE;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    case (op_class_s)
                        CLS_ALU: begin
                            state_r <= ST_EXEC;
                        end
                        CLS_LW, CLS_STORE: begin
                            state_r <= ST_MEM;
                        end
                        CLS_NOP, CLS_ILLEGAL: begin
                            pc_r    <= pc_inc_s;
                            state_r <= ST_FETCH;
                        end
                        CLS_BR: begin
                            pc_r    <= br_taken_s ? pc_br_s : pc_inc_s;
                            state_r <= ST_FETCH;
                        end
                        CLS_HALT: begin
                            state_r <= ST_HALT;
                        end
                        default: begin
                            state_r <= ST_FETCH;
                        end
                    endcase
                end
                ST_EXEC: begin
                    state_r <= ST_WB;
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        if (op_class_s == CLS_STORE) begin
                            pc_r    <= pc_inc_s;
                            state_r <= ST_FETCH;
                        end else begin
                            state_r <= ST_WB;
                        end
                    end else begin
                        state_r <= ST_MEM;
                    end
                end
                ST_WB: begin
                    pc_r    <= pc_inc_s;
                    state_r <= ST_FETCH;
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_s;
    assign imem_addr   = pc_r;
    assign dmem_req    = dmem_req_s;
    assign dmem_we     = dmem_we_s;
    assign pc          = pc_r;
    assign ir          = ir_r;
    assign alu_en      = alu_en_s;
    assign rf_we       = rf_we_s;
    assign retire      = retire_s;
    assign illegal     = illegal_s;
    assign halted      = (state_r == ST_HALT);
    assign retired_cnt = retired_cnt_r;
    assign state       = state_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed, table-driven bench for instr_sequencer (PC_W=8, RESET_PC=0).
// Each table row holds the inputs for one clock cycle and the outputs expected
// during that cycle, before the next rising edge. A short hand-written store
// sequence with a random data-memory wait follows the table.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int PC_W = 8;

    // Flag bit order: {imem_req, dmem_req, dmem_we, alu_en, rf_we, retire, illegal, halted}
    localparam logic [7:0] F_NONE = 8'h00;
    localparam logic [7:0] F_IREQ = 8'h80;
    localparam logic [7:0] F_DREQ = 8'h40;
    localparam logic [7:0] F_DWE  = 8'h20;
    localparam logic [7:0] F_ALU  = 8'h10;
    localparam logic [7:0] F_RFWE = 8'h08;
    localparam logic [7:0] F_RET  = 8'h04;
    localparam logic [7:0] F_ILL  = 8'h02;
    localparam logic [7:0] F_HLT  = 8'h01;

    typedef struct {
        logic        rst_n;
        logic        iack;
        logic [15:0] irdata;
        logic        dack;
        logic        zero;
        logic [2:0]  exp_state;
        logic [7:0]  exp_pc;
        logic [15:0] exp_ir;
        logic [15:0] exp_cnt;
        logic [7:0]  exp_flags;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ack;
    logic            zero;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic            alu_en;
    logic            rf_we;
    logic            retire;
    logic            illegal;
    logic            halted;
    logic [15:0]     retired_cnt;
    logic [2:0]      state;

    int n_vec;
    int n_bad;

    vec_t tbl[$];

    instr_sequencer #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .zero        (zero),
        .pc          (pc),
        .ir          (ir),
        .alu_en      (alu_en),
        .rf_we       (rf_we),
        .retire      (retire),
        .illegal     (illegal),
        .halted      (halted),
        .retired_cnt (retired_cnt),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic ia, input logic [15:0] rd,
                                input logic da, input logic z, input logic [2:0] st,
                                input logic [7:0] p, input logic [15:0] i,
                                input logic [15:0] c, input logic [7:0] f);
        vec_t v;
        v.rst_n = r;  v.iack = ia; v.irdata = rd; v.dack = da; v.zero = z;
        v.exp_state = st; v.exp_pc = p; v.exp_ir = i; v.exp_cnt = c; v.exp_flags = f;
        return v;
    endfunction

    task automatic drive(input logic r, input logic ia, input logic [15:0] rd,
                         input logic da, input logic z);
        rst_n = r; imem_ack = ia; imem_rdata = rd; dmem_ack = da; zero = z;
    endtask

    // Compare every observable output against one expected record.
    task automatic check(input string name, input logic [2:0] st, input logic [7:0] p,
                         input logic [15:0] i, input logic [15:0] c, input logic [7:0] f);
        logic [7:0] act_f;
        act_f = {imem_req, dmem_req, dmem_we, alu_en, rf_we, retire, illegal, halted};
        n_vec++;
        if (state !== st || pc !== p || imem_addr !== p || ir !== i ||
            retired_cnt !== c || act_f !== f) begin
            n_bad++;
            $display("FAIL %s: got state=%0d pc=%h addr=%h ir=%h cnt=%h flags=%b; want state=%0d pc=%h ir=%h cnt=%h flags=%b",
                     name, state, pc, imem_addr, ir, retired_cnt, act_f, st, p, i, c, f);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // ADD 0x1123 at pc 0: FETCH, DECODE, EXEC, WB.
        tbl.push_back(mk(1'b1, 1'b1, 16'h1123, 1'b0, 1'b0, 3'd0, 8'h00, 16'h0000, 16'd0, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b1, 16'h1123, 1'b0, 1'b0, 3'd1, 8'h00, 16'h1123, 16'd0, F_NONE));
        tbl.push_back(mk(1'b1, 1'b1, 16'h1123, 1'b0, 1'b0, 3'd2, 8'h00, 16'h1123, 16'd0, F_ALU));
        tbl.push_back(mk(1'b1, 1'b1, 16'h1123, 1'b0, 1'b0, 3'd4, 8'h00, 16'h1123, 16'd0, F_RFWE | F_RET));
        // LW 0x8000 at pc 1, dmem ack after three wait cycles.
        tbl.push_back(mk(1'b1, 1'b1, 16'h8000, 1'b0, 1'b0, 3'd0, 8'h01, 16'h1123, 16'd1, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1, 8'h01, 16'h8000, 16'd1, F_NONE));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd3, 8'h01, 16'h8000, 16'd1, F_DREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 8'h01, 16'h8000, 16'd1, F_DREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd4, 8'h01, 16'h8000, 16'd1, F_RFWE | F_RET));
        // SW 0x9000 at pc 2, zero-wait: retires on the ack cycle in MEM.
        tbl.push_back(mk(1'b1, 1'b1, 16'h9000, 1'b0, 1'b0, 3'd0, 8'h02, 16'h8000, 16'd2, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1, 8'h02, 16'h9000, 16'd2, F_NONE));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 8'h02, 16'h9000, 16'd2, F_DREQ | F_DWE | F_RET));
        // BNZ 0xD00C at pc 3, zero=0: taken to 3+1+12 = 0x10.
        tbl.push_back(mk(1'b1, 1'b1, 16'hD00C, 1'b0, 1'b0, 3'd0, 8'h03, 16'h9000, 16'd3, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1, 8'h03, 16'hD00C, 16'd3, F_RET));
        // BEZ 0xC0FE at 0x10, zero=1, one imem wait: taken to 0x0F.
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 8'h10, 16'hD00C, 16'd4, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b1, 16'hC0FE, 1'b0, 1'b0, 3'd0, 8'h10, 16'hD00C, 16'd4, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd1, 8'h10, 16'hC0FE, 16'd4, F_RET));
        // NOP at 0x0F -> 0x10.
        tbl.push_back(mk(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 8'h0F, 16'hC0FE, 16'd5, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1, 8'h0F, 16'h0000, 16'd5, F_RET));
        // BNZ 0xD005 at 0x10, zero=1: not taken -> 0x11.
        tbl.push_back(mk(1'b1, 1'b1, 16'hD005, 1'b0, 1'b0, 3'd0, 8'h10, 16'h0000, 16'd6, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd1, 8'h10, 16'hD005, 16'd6, F_RET));
        // BEZ 0xC0FE at 0x11, zero=1 -> 0x10.
        tbl.push_back(mk(1'b1, 1'b1, 16'hC0FE, 1'b0, 1'b0, 3'd0, 8'h11, 16'hD005, 16'd7, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd1, 8'h11, 16'hC0FE, 16'd7, F_RET));
        // BNZ 0xD005 at 0x10, zero=0: taken -> 0x16.
        tbl.push_back(mk(1'b1, 1'b1, 16'hD005, 1'b0, 1'b0, 3'd0, 8'h10, 16'hC0FE, 16'd8, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1, 8'h10, 16'hD005, 16'd8, F_RET));
        // BEZ 0xC0E8 at 0x16, zero=1: 0x17 + 0xE8 = 0xFF.
        tbl.push_back(mk(1'b1, 1'b1, 16'hC0E8, 1'b0, 1'b0, 3'd0, 8'h16, 16'hD005, 16'd9, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd1, 8'h16, 16'hC0E8, 16'd9, F_RET));
        // Illegal 0x7000 at 0xFF: illegal + retire, pc wraps to 0x00.
        tbl.push_back(mk(1'b1, 1'b1, 16'h7000, 1'b0, 1'b0, 3'd0, 8'hFF, 16'hC0E8, 16'd10, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1, 8'hFF, 16'h7000, 16'd10, F_RET | F_ILL));
        // HALT 0xF000 at 0x00, then 20 cycles halted with acks ignored.
        tbl.push_back(mk(1'b1, 1'b1, 16'hF000, 1'b0, 1'b0, 3'd0, 8'h00, 16'h7000, 16'd11, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b1, 16'h1123, 1'b1, 1'b0, 3'd1, 8'h00, 16'hF000, 16'd11, F_RET));
        for (int k = 0; k < 20; k++)
            tbl.push_back(mk(1'b1, 1'b1, 16'h1123, 1'b1, 1'b0, 3'd5, 8'h00, 16'hF000, 16'd12, F_HLT));
        // Reset out of HALT, with acks present during reset.
        tbl.push_back(mk(1'b0, 1'b1, 16'h1123, 1'b1, 1'b0, 3'd5, 8'h00, 16'hF000, 16'd12, F_HLT));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 8'h00, 16'h0000, 16'd0, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1, 8'h00, 16'h0000, 16'd0, F_RET));
        // LW at pc 1, reset while waiting in MEM with dmem_ack arriving at that edge.
        tbl.push_back(mk(1'b1, 1'b1, 16'h8000, 1'b0, 1'b0, 3'd0, 8'h01, 16'h0000, 16'd1, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1, 8'h01, 16'h8000, 16'd1, F_NONE));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd3, 8'h01, 16'h8000, 16'd1, F_DREQ));
        tbl.push_back(mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd3, 8'h01, 16'h8000, 16'd1, F_DREQ));
        // Late dmem acks after reset must not move the sequencer.
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 8'h00, 16'h0000, 16'd0, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 8'h00, 16'h0000, 16'd0, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 8'h00, 16'h0000, 16'd0, F_IREQ));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1, 8'h00, 16'h0000, 16'd0, F_RET));
        tbl.push_back(mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 8'h01, 16'h0000, 16'd1, F_IREQ));

        // Initial reset.
        repeat (2) @(posedge clk);

        for (int n = 0; n < tbl.size(); n++) begin
            #1;
            drive(tbl[n].rst_n, tbl[n].iack, tbl[n].irdata, tbl[n].dack, tbl[n].zero);
            @(negedge clk);
            check($sformatf("vec%0d", n), tbl[n].exp_state, tbl[n].exp_pc, tbl[n].exp_ir,
                  tbl[n].exp_cnt, tbl[n].exp_flags);
            @(posedge clk);
        end

        // SWI 0xA000 at pc 1 with a random number of data-memory wait cycles.
        begin
            int w;
            w = int'($urandom_range(1, 6));
            #1 drive(1'b1, 1'b1, 16'hA000, 1'b0, 1'b0);
            @(negedge clk);
            check("swi_fetch", 3'd0, 8'h01, 16'h0000, 16'd1, F_IREQ);
            @(posedge clk);
            #1 drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
            @(negedge clk);
            check("swi_decode", 3'd1, 8'h01, 16'hA000, 16'd1, F_NONE);
            @(posedge clk);
            for (int k = 0; k < w; k++) begin
                #1 drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
                @(negedge clk);
                check($sformatf("swi_wait%0d", k), 3'd3, 8'h01, 16'hA000, 16'd1, F_DREQ | F_DWE);
                @(posedge clk);
            end
            #1 drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
            @(negedge clk);
            check("swi_ack", 3'd3, 8'h01, 16'hA000, 16'd1, F_DREQ | F_DWE | F_RET);
            @(posedge clk);
            #1 drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
            @(negedge clk);
            check("swi_done", 3'd0, 8'h02, 16'hA000, 16'd2, F_IREQ);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
